field_row_prefetch: RTL
=======================

Name: field_row_prefetch

Overview:
Sequences reads of the single-port field cell RAM (BRICK_X_CNT x BRICK_Y_CNT cells) for the field renderer. It also shares that RAM with game logic.
- On each line-start strobe it locates the brick row of the upcoming display line and prefetches that row into a double-buffered line cache. The draw path then reads the cache by brick column.
- Game logic gets the RAM through a valid/ready port whenever no prefetch is running.

Parameters:
PIX_WIDTH, 12, pixel coordinate width
BRICK_Y, 25, brick height in pixels
BRICK_X_CNT, 10, bricks per row
BRICK_Y_CNT, 20, brick rows
BORDER_Y, 2, gap between rows in pixels
CELL_W, 3, cell value width (0 = empty)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_y_i  in  PIX_WIDTH  field top pixel
line_start_i  in  1  one-cycle strobe, one display line ahead of target line
next_pix_y_i  in  PIX_WIDTH  y of target line, valid with line_start_i
mem_addr_o  out  ADDR_W  RAM address (ADDR_W = $clog2(BRICK_X_CNT*BRICK_Y_CNT)), row*BRICK_X_CNT+col
mem_we_o  out  1  RAM write enable
mem_wdata_o  out  CELL_W  RAM write data
mem_rdata_i  in  CELL_W  RAM read data, 1-cycle latency
game_valid_i  in  1  game request valid
game_ready_o  out  1  game request accepted when valid&&ready
game_we_i  in  1  1 = write, 0 = read
game_row_i  in  $clog2(BRICK_Y_CNT)  cell row
game_col_i  in  $clog2(BRICK_X_CNT)  cell column
game_wdata_i  in  CELL_W  write data
game_rsp_valid_o  out  1  read response strobe
game_rsp_data_o  out  CELL_W  read data
disp_col_i  in  $clog2(BRICK_X_CNT)  brick column from draw helper
disp_cell_o  out  CELL_W  cell at (displayed row, disp_col_i), registered
disp_hit_o  out  1  current line lies inside a brick row
overrun_o  out  1  sticky: line_start_i arrived mid-fetch

Behaviour:
- Reset: all outputs 0; FSM IDLE; back_valid = pending_valid = front_hit = 0; front_ptr = 0; overrun_o cleared only by rst.
- Row locate (combinational): off = next_pix_y_i - start_y_i (PIX_WIDTH, wraps).
  - Row r is hit iff off in [(r+1)*BORDER_Y + r*BRICK_Y, that + BRICK_Y - 1].
  - Off in a border or beyond the field means miss; wrapped (negative) off means miss.
- On line_start_i, this fixed order applies:
  1. front_hit <= pending_hit, except overrun case below. If back_valid, front_ptr flips and back_valid <= 0.
  2. pending_hit/pending_row <= locate result.
  3. A fetch of row r into back starts (FSM -> FETCH) iff hit && !(pending_valid && r == pending_row). Otherwise FSM stays IDLE; the retained front is reused.
  4. pending_valid <= hit.
- FETCH: issues addresses r*BRICK_X_CNT + c for c = 0..BRICK_X_CNT-1, one per cycle, mem_we_o = 0.
  - Data is written into back[c] one cycle later.
  - DRAIN covers one cycle for the last datum, then back_valid <= 1 and FSM -> IDLE.
  - Total is BRICK_X_CNT+1 cycles.
- Overrun: line_start_i while FETCH or DRAIN.
  - Abort the fetch; overrun_o <= 1; back_valid <= 0; front_hit <= 0 for the next line.
  - Then apply steps 2-4 normally; the restart is forced even if the row matches.
- Arbitration: game_ready_o = (FSM == IDLE) && !line_start_i; the prefetch has absolute priority.
  - On an accepted request, drive mem_* that cycle.
  - For a read, game_rsp_valid_o = 1 exactly one cycle later with mem_rdata_i. Writes produce no response.
- Coherence: an accepted write also updates front[col] if front_hit row == game_row_i, and back[col] if back_valid && row matches, in the same cycle.
- Display: disp_cell_o <= front_hit ? front[disp_col_i] : 0, with 1-cycle latency. disp_hit_o <= front_hit.
- disp_col_i >= BRICK_X_CNT yields 0.

Decomposition:
- Package field_pkg holds: cell_t (logic [CELL_W-1:0]), cell encodings (0 empty, 1-7 piece colours), and fsm_t {IDLE, FETCH, DRAIN}.
- One sub-module, field_row_locator: the combinational off -> {hit, row} mapping, reusable by the draw helper.

Test Plan:
1. start_y_i=100, line_start_i with next_pix_y_i=102 -> row 0 fetch, mem_addr_o 0..9 on consecutive cycles. After the next strobe, disp_hit_o=1 and disp_cell_o equals the RAM row 0 contents per column.
2. next_pix_y_i=101, then 640 -> miss on both (border / bottom border); no RAM access; disp_hit_o=0 after swap. next_pix_y_i=639 -> row 19, addresses 190..199.
3. Strobes at y=102, 103, 104 (all row 0) -> exactly one fetch of 10 reads; front retained; display stays row 0.
4. Game read of (3,4) held valid during FETCH -> game_ready_o=0 until IDLE. Then accept with addr 34; rsp_valid one cycle later with the RAM data.
5. Game write (0,5)=6 while row 0 is displayed -> RAM written at addr 5; disp_cell_o for col 5 becomes 6 next cycle.
6. line_start_i 5 cycles into a fetch -> overrun_o=1 (sticky); next line disp_hit_o=0; a new full 10-read fetch starts; rst clears overrun_o.

Source files
------------

// File: rtl/field_pkg.sv
// Shared types and geometry for the field cell RAM and its row prefetcher.
package field_pkg;

  localparam int PIX_WIDTH   = 12;
  localparam int BRICK_Y     = 25;
  localparam int BRICK_X_CNT = 10;
  localparam int BRICK_Y_CNT = 20;
  localparam int BORDER_Y    = 2;
  localparam int CELL_W      = 3;

  localparam int ADDR_W = $clog2(BRICK_X_CNT * BRICK_Y_CNT);
  localparam int ROW_W  = $clog2(BRICK_Y_CNT);
  localparam int COL_W  = $clog2(BRICK_X_CNT);

  typedef logic [CELL_W-1:0] cell_t;

  // 0 is empty; 1..7 are piece colours.
  localparam cell_t CELL_EMPTY = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fsm_t;

  function automatic logic [PIX_WIDTH-1:0] row_top(input int r);
    return PIX_WIDTH'((r + 1) * BORDER_Y + r * BRICK_Y);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(BRICK_X_CNT) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/field_row_locator.sv
// Maps a pixel offset from the field top to the brick row it falls in, if any.
module field_row_locator
  import field_pkg::*;
(
  input  logic [PIX_WIDTH-1:0] i_off,
  output logic                 o_hit,
  output logic [ROW_W-1:0]     o_row
);

  // Wrapped (negative) offsets are huge unsigned values and match no row.
  always_comb begin
    o_hit = 1'b0;
    o_row = '0;
    for (int r = 0; r < BRICK_Y_CNT; r++) begin
      if (i_off >= row_top(r) && i_off <= row_top(r) + PIX_WIDTH'(BRICK_Y - 1)) begin
        o_hit = 1'b1;
        o_row = ROW_W'(r);
      end
    end
  end

endmodule

// File: rtl/field_row_prefetch.sv
// Prefetches the brick row of the next display line into a double-buffered
// line cache and arbitrates the single-port field RAM with game logic.
module field_row_prefetch
  import field_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_WIDTH-1:0] start_y_i,
  input  logic                 line_start_i,
  input  logic [PIX_WIDTH-1:0] next_pix_y_i,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_we_o,
  output cell_t                mem_wdata_o,
  input  cell_t                mem_rdata_i,
  input  logic                 game_valid_i,
  output logic                 game_ready_o,
  input  logic                 game_we_i,
  input  logic [ROW_W-1:0]     game_row_i,
  input  logic [COL_W-1:0]     game_col_i,
  input  cell_t                game_wdata_i,
  output logic                 game_rsp_valid_o,
  output cell_t                game_rsp_data_o,
  input  logic [COL_W-1:0]     disp_col_i,
  output cell_t                disp_cell_o,
  output logic                 disp_hit_o,
  output logic                 overrun_o
);

  localparam logic [COL_W-1:0] NUM_COLS = COL_W'(BRICK_X_CNT);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BRICK_X_CNT - 1);

  fsm_t r_state, w_state_nxt;

  cell_t            r_cache [2][BRICK_X_CNT];
  logic             r_front_ptr, r_front_hit, r_back_valid;
  logic [ROW_W-1:0] r_front_row, r_back_row;
  logic             r_pending_valid, r_pending_hit;
  logic [ROW_W-1:0] r_pending_row;
  logic [COL_W-1:0] r_col, r_cap_col;
  logic             r_cap_en, r_overrun, r_rsp_valid, r_disp_hit;
  cell_t            r_disp_cell;

  logic [PIX_WIDTH-1:0] w_off;
  logic                 w_loc_hit, w_busy, w_start, w_game_acc, w_back_ptr;
  logic [ROW_W-1:0]     w_loc_row;

  assign w_off = next_pix_y_i - start_y_i;

  field_row_locator u_locator (
    .i_off (w_off),
    .o_hit (w_loc_hit),
    .o_row (w_loc_row)
  );

  assign w_busy     = (r_state != IDLE);
  assign w_back_ptr = ~r_front_ptr;
  // A strobe during a fetch forces a restart even when the row is unchanged.
  assign w_start    = line_start_i && w_loc_hit &&
                      (w_busy || !(r_pending_valid && (w_loc_row == r_pending_row)));
  assign w_game_acc = game_valid_i && game_ready_o;

  assign game_ready_o     = (r_state == IDLE) && !line_start_i && !rst;
  assign game_rsp_valid_o = r_rsp_valid;
  assign game_rsp_data_o  = r_rsp_valid ? mem_rdata_i : CELL_EMPTY;
  assign disp_cell_o      = r_disp_cell;
  assign disp_hit_o       = r_disp_hit;
  assign overrun_o        = r_overrun;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = CELL_EMPTY;
    if (line_start_i) begin
      w_state_nxt = w_start ? FETCH : IDLE;
    end else begin
      case (r_state)
        FETCH:   if (r_col == LAST_COL) w_state_nxt = DRAIN;
        DRAIN:   w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
    if (r_state == FETCH) begin
      mem_addr_o = addr_of(r_back_row, r_col);
    end else if (w_game_acc) begin
      mem_addr_o  = addr_of(game_row_i, game_col_i);
      mem_we_o    = game_we_i;
      mem_wdata_o = game_we_i ? game_wdata_i : CELL_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_front_ptr     <= 1'b0;
      r_front_hit     <= 1'b0;
      r_front_row     <= '0;
      r_back_valid    <= 1'b0;
      r_back_row      <= '0;
      r_pending_valid <= 1'b0;
      r_pending_hit   <= 1'b0;
      r_pending_row   <= '0;
      r_col           <= '0;
      r_cap_col       <= '0;
      r_cap_en        <= 1'b0;
      r_overrun       <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_disp_hit      <= 1'b0;
      r_disp_cell     <= CELL_EMPTY;
    end else begin
      r_rsp_valid <= w_game_acc && !game_we_i;
      r_disp_hit  <= r_front_hit;
      r_disp_cell <= (r_front_hit && disp_col_i < NUM_COLS) ?
                     r_cache[r_front_ptr][disp_col_i] : CELL_EMPTY;

      // RAM data lags the address by one cycle, so capture lags the issue.
      r_cap_en  <= (r_state == FETCH) && !line_start_i;
      r_cap_col <= r_col;
      if (r_cap_en) r_cache[w_back_ptr][r_cap_col] <= mem_rdata_i;
      if (r_state == FETCH) r_col <= r_col + 1'b1;
      if (r_state == DRAIN && !line_start_i) r_back_valid <= 1'b1;

      if (w_game_acc && game_we_i && game_col_i < NUM_COLS) begin
        if (r_front_hit && r_front_row == game_row_i)
          r_cache[r_front_ptr][game_col_i] <= game_wdata_i;
        if (r_back_valid && r_back_row == game_row_i)
          r_cache[w_back_ptr][game_col_i] <= game_wdata_i;
      end

      if (line_start_i) begin
        if (w_busy) begin
          r_overrun    <= 1'b1;
          r_back_valid <= 1'b0;
          r_front_hit  <= 1'b0;
        end else begin
          r_front_hit <= r_pending_hit;
          if (r_back_valid) begin
            r_front_ptr  <= ~r_front_ptr;
            r_front_row  <= r_back_row;
            r_back_valid <= 1'b0;
          end
        end
        r_pending_hit   <= w_loc_hit;
        r_pending_row   <= w_loc_row;
        r_pending_valid <= w_loc_hit;
        if (w_start) begin
          r_back_row <= w_loc_row;
          r_col      <= '0;
        end
      end
    end
  end

endmodule
